// File: rtl/activity_dff_bank_pkg.sv
// rtl/activity_dff_bank_pkg.sv - shared types and arithmetic helpers for activity_dff_bank
//
// Purpose : capture-edge selector enum, a width-bounded popcount and a
//           saturating adder used by the activity counters.
// Ports   : none (package).

package activity_dff_pkg;

  typedef enum logic [1:0] {
    EDGE_POS  = 2'd0,
    EDGE_NEG  = 2'd1,
    EDGE_DUAL = 2'd2
  } edge_mode_e;

  // Largest bank the popcount helper can scan, and the widest counter the
  // saturating adder can hold. Callers zero-extend into these widths.
  localparam int unsigned POP_MAX_W = 256;
  localparam int unsigned SAT_MAX_W = 32;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Counts set bits in v[w-1:0]. Bits at or above w are ignored, so the
  // caller's bank width is the effective parameter of the function.
  function automatic logic [15:0] popcount(input logic [POP_MAX_W-1:0] v,
                                           input int unsigned          w);
    logic [15:0] n;
    n = '0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (i < w) n = n + 16'(v[i]);
    end
    return n;
  endfunction

  // a + b evaluated one bit wider than the counter; anything above
  // 2^cnt_w-1 clamps to all-ones and flags ovf.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                       input logic [SAT_MAX_W-1:0] b,
                                       input int unsigned          cnt_w);
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] limit;
    sat_res_t           r;
    full  = {1'b0, a} + {1'b0, b};
    limit = ((SAT_MAX_W+1)'(1) << cnt_w) - (SAT_MAX_W+1)'(1);
    if (full > limit) begin
      r.ovf = 1'b1;
      r.sum = limit[SAT_MAX_W-1:0];
    end else begin
      r.ovf = 1'b0;
      r.sum = full[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/activity_dff_bank_if.sv
// rtl/activity_dff_bank_if.sv - data/counter bundle between activity_dff_bank and its user
//
// Purpose : groups capture inputs and activity outputs of the bank.
// Signals : EN      capture enable
//           D       data input (WIDTH)
//           CLR     synchronous counter clear
//           Q       registered data (WIDTH)
//           TOG_CNT saturating total of Q bit toggles (CNT_W)
//           EVT_CNT saturating count of capture edges that changed Q (CNT_W)
//           SAT     sticky saturation flag
// Modports: master drives EN/D/CLR, slave (the bank) drives the rest.

interface activity_dff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             EN;
  logic [WIDTH-1:0] D;
  logic             CLR;
  logic [WIDTH-1:0] Q;
  logic [CNT_W-1:0] TOG_CNT;
  logic [CNT_W-1:0] EVT_CNT;
  logic             SAT;

  modport master (
    output EN, D, CLR,
    input  Q, TOG_CNT, EVT_CNT, SAT
  );

  modport slave (
    input  EN, D, CLR,
    output Q, TOG_CNT, EVT_CNT, SAT
  );

endinterface

// File: rtl/activity_dff_bank_dual_edge_reg.sv
// rtl/activity_dff_bank_dual_edge_reg.sv - dual-edge register built from two XOR-coupled half-flops
//
// Purpose : captures D on both CLK edges without a clock-driven output mux.
// Ports   : CLK  clock, both edges active
//           RST  asynchronous active-high reset
//           EN   capture enable, sampled at each edge
//           D    data input (WIDTH)
//           Q    registered data (WIDTH), qp ^ qn

module dual_edge_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] qp;
  logic [WIDTH-1:0] qn;

  // Each half stores D pre-XORed with the other half, so whichever half
  // updated last makes qp ^ qn equal to the D it sampled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      qp <= '0;
    end else if (EN) begin
      qp <= D ^ qn;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      qn <= '0;
    end else if (EN) begin
      qn <= D ^ qp;
    end
  end

  assign Q = qp ^ qn;

endmodule

// File: rtl/activity_dff_bank.sv
// rtl/activity_dff_bank.sv - WIDTH-bit register bank with selectable capture edge and toggle counters
//
// Purpose : registers D on the rising, falling or both CLK edges and keeps
//           saturating counts of Q bit toggles and of Q-changing captures.
// Params  : WIDTH     data bits (1..POP_MAX_W)
//           EDGE_MODE EDGE_POS, EDGE_NEG or EDGE_DUAL
//           CNT_W     counter width (4..SAT_MAX_W)
// Ports   : CLK  clock
//           RST  asynchronous active-high reset
//           bus  activity_dff_bank_if slave (EN, D, CLR in; Q, TOG_CNT,
//                EVT_CNT, SAT out)

module activity_dff_bank
  import activity_dff_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter edge_mode_e EDGE_MODE = EDGE_POS,
  parameter int         CNT_W     = 16
) (
  input logic                CLK,
  input logic                RST,
  activity_dff_bank_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d_xor_q;

  // Contribution of a capture happening at the edge currently being taken:
  // q is still the pre-edge value here.
  logic [15:0] edge_tog;
  logic        edge_evt;

  logic [15:0] cur_tog;
  logic        cur_evt;
  logic [15:0] pend_tog;
  logic        pend_evt;

  logic [CNT_W-1:0] tog_cnt;
  logic [CNT_W-1:0] evt_cnt;
  logic             sat;

  logic [SAT_MAX_W-1:0] tog_inc;
  logic [SAT_MAX_W-1:0] evt_inc;
  sat_res_t             tog_res;
  sat_res_t             evt_res;

  assign d_xor_q  = bus.D ^ q;
  assign edge_tog = bus.EN ? popcount(POP_MAX_W'(d_xor_q), unsigned'(WIDTH)) : 16'd0;
  assign edge_evt = bus.EN && (|d_xor_q);

  // ------------------------------------------------------------------
  // Data register
  // ------------------------------------------------------------------
  generate
    if (EDGE_MODE == EDGE_DUAL) begin : g_dual
      dual_edge_reg #(
        .WIDTH (WIDTH)
      ) u_dual_edge_reg (
        .CLK (CLK),
        .RST (RST),
        .EN  (bus.EN),
        .D   (bus.D),
        .Q   (q)
      );
    end else if (EDGE_MODE == EDGE_NEG) begin : g_neg
      always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
          q <= '0;
        end else if (bus.EN) begin
          q <= bus.D;
        end
      end
    end else begin : g_pos
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          q <= '0;
        end else if (bus.EN) begin
          q <= bus.D;
        end
      end
    end
  endgenerate

  // ------------------------------------------------------------------
  // Falling-edge contributions are parked here until the next rising edge,
  // because the counters themselves only ever change on rising CLK. Every
  // rising edge is preceded by exactly one falling edge (or by reset), so
  // the value is consumed once without needing an explicit clear.
  // ------------------------------------------------------------------
  generate
    if (EDGE_MODE == EDGE_POS) begin : g_no_pend
      assign pend_tog = 16'd0;
      assign pend_evt = 1'b0;
    end else begin : g_pend
      always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
          pend_tog <= 16'd0;
          pend_evt <= 1'b0;
        end else begin
          pend_tog <= edge_tog;
          pend_evt <= edge_evt;
        end
      end
    end

    if (EDGE_MODE == EDGE_NEG) begin : g_no_cur
      assign cur_tog = 16'd0;
      assign cur_evt = 1'b0;
    end else begin : g_cur
      assign cur_tog = edge_tog;
      assign cur_evt = edge_evt;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Activity counters (rising edge only)
  // ------------------------------------------------------------------
  assign tog_inc = SAT_MAX_W'(pend_tog) + SAT_MAX_W'(cur_tog);
  assign evt_inc = SAT_MAX_W'(pend_evt) + SAT_MAX_W'(cur_evt);

  assign tog_res = sat_add(SAT_MAX_W'(tog_cnt), tog_inc, unsigned'(CNT_W));
  assign evt_res = sat_add(SAT_MAX_W'(evt_cnt), evt_inc, unsigned'(CNT_W));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tog_cnt <= '0;
      evt_cnt <= '0;
      sat     <= 1'b0;
    end else if (bus.CLR) begin
      // Clear wins over this edge's contributions, pending ones included.
      tog_cnt <= '0;
      evt_cnt <= '0;
      sat     <= 1'b0;
    end else begin
      tog_cnt <= tog_res.sum[CNT_W-1:0];
      evt_cnt <= evt_res.sum[CNT_W-1:0];
      if (tog_res.ovf || evt_res.ovf) begin
        sat <= 1'b1;
      end
    end
  end

  // Clamped sums never exceed CNT_W bits, so the adder's upper bits are
  // always zero and deliberately left unconsumed.
  generate
    if (CNT_W < SAT_MAX_W) begin : g_sum_hi
      logic unused_sum_hi;
      assign unused_sum_hi = ^{tog_res.sum[SAT_MAX_W-1:CNT_W],
                               evt_res.sum[SAT_MAX_W-1:CNT_W]};
    end
  endgenerate

  assign bus.Q       = q;
  assign bus.TOG_CNT = tog_cnt;
  assign bus.EVT_CNT = evt_cnt;
  assign bus.SAT     = sat;

endmodule

// File: doc/activity_dff_bank.md
# activity_dff_bank

Parametrised register bank with a selectable capture edge (rising, falling or both) and built-in switching-activity counters. It generalises the single-bit, fixed-behaviour flop cells in the minimal power-analysis tests to a WIDTH-bit bank. It reports per-run toggle statistics so simulated activity can be cross-checked against the power-analysis flow's activity logs. It sits in the example designs as the reference sequential cell for edge-mode and activity comparisons.

## Interface
- WIDTH, 8, data bits in the bank (≥1)
- EDGE_MODE, EDGE_POS, capture edge: EDGE_POS, EDGE_NEG or EDGE_DUAL
- CNT_W, 16, width of each activity counter (≥4)

- CLK  in  1  single clock; all state is clocked by CLK (rising and/or falling edge per EDGE_MODE)
- RST  in  1  asynchronous, active-high reset
- EN  in  1  capture enable, sampled at each capture edge
- D  in  WIDTH  data input
- CLR  in  1  synchronous counter clear, sampled on rising CLK
- Q  out  WIDTH  registered data
- TOG_CNT  out  CNT_W  total Q bit toggles since reset/clear, saturating
- EVT_CNT  out  CNT_W  count of capture edges at which Q changed (≥1 bit), saturating
- SAT  out  1  sticky: either counter has saturated

## Operation
- Capture: at each active edge with EN=1, Q takes D. With EN=0, Q holds.
  - EDGE_POS: rising edge only.
  - EDGE_NEG: falling edge only.
  - EDGE_DUAL: both edges.
- DUAL implementation: two half-flops using the XOR scheme. On rising edges qp <= D^qn; on falling edges qn <= D^qp; Q = qp^qn. No CLK-driven mux on Q.
- Toggle amount per capture edge = popcount(D ^ Q_before_edge) when EN=1, else 0.
- Counters update on rising CLK only:
  - Rising-edge captures are added at the same edge.
  - Falling-edge captures are latched into a pending register (pend_tog, pend_evt) on the falling edge. They are added at the next rising edge.
  - In EDGE_DUAL, one rising edge can therefore add both pending and current contributions: TOG_CNT += pend_tog + cur_tog, and EVT_CNT += pend_evt + cur_evt (0..2).
  - In EDGE_NEG, only the pending contribution is ever added.
- Arithmetic: sums are computed at CNT_W+1 bits. A result above 2^CNT_W-1 clamps to all-ones and sets SAT.
- CLR=1 at a rising edge: TOG_CNT, EVT_CNT and SAT go to 0. All contributions at that edge, including pending ones, are discarded. Q is unaffected.
- SAT clears only on CLR or RST.

## Timing
- Reset values: Q=0, qp=qn=0, TOG_CNT=0, EVT_CNT=0, SAT=0, pend_tog=pend_evt=0.
- RST assertion clears all state immediately, regardless of CLK level. The first capture after deassertion is at the next active edge.
- Q latency: same edge as the capture; visible after clock-to-Q. No pipeline.
- Counter latency:
  - Rising-edge toggles appear on the same rising edge.
  - Falling-edge toggles appear on the following rising edge, half a cycle later.
- Reset mid-cycle between a falling and a rising edge discards the pending falling-edge contribution.
- EN is sampled independently at every active edge. In DUAL, EN=1 only during CLK high captures at falling edges only.

## Structure
- Package activity_dff_pkg:
  - edge_mode_e (EDGE_POS=0, EDGE_NEG=1, EDGE_DUAL=2).
  - popcount function parametrised on width.
  - sat_add function (a, b, CNT_W), returning the clamped sum and an overflow bit.
- Sub-module dual_edge_reg (WIDTH): the qp/qn XOR pair, with async RST.
  - Instantiated only under EDGE_DUAL via generate.
  - POS/NEG modes use a plain always_ff on the selected edge.
- Counter logic lives in the top module.

## Test plan
- POS, WIDTH=8, period 10, RST released at t=12. D=0x00→0xFF before edge 1, then 0x0F before edge 2 → Q=0xFF then 0x0F; TOG_CNT=8 then 12; EVT_CNT=1 then 2.
- DUAL, D alternates 0x01/0x00 every half period for 4 cycles → Q follows on each edge. TOG_CNT increments by 2 per rising edge after the first: final 8 for 8 captures. EVT_CNT=8. Verify pending handling.
- NEG, EN=0 for edges 1–2, EN=1 afterwards with D=0xA5 → Q stays 0 through edge 2, then 0xA5 at the next falling edge. TOG_CNT=4 at the following rising edge.
- CNT_W=4, WIDTH=8, D toggles 0x00/0xFF each POS edge → TOG_CNT 8 then 15 (clamped), SAT=1. CLR pulse → all 0 with SAT=0, Q unchanged.
- DUAL, RST asserted 2 ns after a falling-edge capture of 0xFF → Q=0 immediately. Next rising edge with RST low and EN=0 → TOG_CNT stays 0 (pending discarded).
- CLR asserted on the same rising edge as an 8-bit toggle in POS → Q updates, TOG_CNT=0 and EVT_CNT=0 afterwards.
